mem_port_arbiter: RTL and testbench

- Shares one PicoRV32-style valid/ready memory slave (the MD5 data TCM) between two requesters.
- Requester 0 is the CPU data bus; requester 1 is a host/DMA loader that preloads message data.
- Round-robin, non-preemptive, one outstanding transfer.
- A watchdog completes hung transfers with an error word, so neither master can deadlock.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_watchdog.sv | 36 +++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Round-robin pick: on contention the requester not served last time wins.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    else if (v1) return 1'b1;
    else return 1'b0;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Grant-cycle counter that flags a transfer stuck for TIMEOUT_CYCLES cycles.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clock, reset, clear, enable};
      assign expired       = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count;

      // Saturates at LAST; the arbiter leaves GRANT in that same cycle anyway.
      always_ff @(posedge clock) begin
        if (!reset || clear) begin
          count <= '0;
        end else if (enable && (count != LAST)) begin
          count <= count + 1'b1;
        end
      end

      assign expired = enable && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one valid/ready memory slave
// between the CPU data bus (m0) and a host/DMA loader (m1).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 16,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic [31:0]           m1_rdata,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic [31:0]           s_rdata,
  output logic [1:0]            o_grant,
  output logic                  o_busy,
  output logic                  o_timeout
);

  // Handshake: a master raises mN_valid with stable addr/wdata/wstrb and holds
  // it until mN_ready; mN_ready is a one-cycle strobe that also qualifies
  // mN_rdata. The slave side is the same: s_valid holds until s_ready.

  arb_state_t state, state_next;
  logic       last_grant, last_grant_next;
  logic       in_grant;
  logic       owner;
  logic       own_valid;
  logic       wd_expired;
  logic       done;
  logic       timeout;
  logic [31:0] done_rdata;

  // Outputs are forced quiet while reset is held so an abandoned transfer
  // never produces a stray ready.
  assign in_grant  = reset && (state != ARB_IDLE);
  assign owner     = (state == ARB_GRANT1);
  assign own_valid = owner ? m1_valid : m0_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_grant),
    .enable  (in_grant && own_valid && !s_ready),
    .expired (wd_expired)
  );

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    done            = 1'b0;
    timeout         = 1'b0;
    done_rdata      = s_rdata;
    case (state)
      ARB_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_next = rr_pick(m0_valid, m1_valid, last_grant) ? ARB_GRANT1 : ARB_GRANT0;
        end
      end
      ARB_GRANT0, ARB_GRANT1: begin
        if (!own_valid) begin
          state_next = ARB_IDLE;
        end else if (s_ready) begin
          done            = 1'b1;
          state_next      = ARB_IDLE;
          last_grant_next = owner;
        end else if (wd_expired) begin
          done            = 1'b1;
          timeout         = 1'b1;
          done_rdata      = ERR_DATA;
          state_next      = ARB_IDLE;
          last_grant_next = owner;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
    if (!reset) begin
      done    = 1'b0;
      timeout = 1'b0;
    end
  end

  assign m0_ready  = done && !owner;
  assign m1_ready  = done && owner;
  assign m0_rdata  = m0_ready ? done_rdata : 32'h0;
  assign m1_rdata  = m1_ready ? done_rdata : 32'h0;
  assign o_timeout = timeout;

  assign s_valid = in_grant;
  assign o_busy  = in_grant;
  assign o_grant = {in_grant && owner, in_grant && !owner};
  assign s_addr  = in_grant ? (owner ? m1_addr  : m0_addr)  : '0;
  assign s_wdata = in_grant ? (owner ? m1_wdata : m0_wdata) : 32'h0;
  assign s_wstrb = in_grant ? (owner ? m1_wstrb : m0_wstrb) : 4'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vector table for the directed corners,
// then a randomized contention run checked through expected-data queues.
module tb_mem_port_arbiter;

  localparam int AW = 16;

  logic          clock;
  logic          reset;
  logic          m0_valid, m1_valid;
  logic          m0_ready, m1_ready;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic [31:0]   s_rdata;
  logic [1:0]    o_grant;
  logic          o_busy;
  logic          o_timeout;

  // manual or automatic slave
  logic          slave_auto;
  logic          man_ready;
  logic [31:0]   man_rdata;
  logic          auto_ready;
  int            wait_cnt;
  int            lat;

  int total;
  int bad;

  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  int          own_q[$];

  function automatic logic [31:0] mem_fn(input logic [AW-1:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  assign s_ready = slave_auto ? auto_ready : man_ready;
  assign s_rdata = slave_auto ? mem_fn(s_addr) : man_rdata;

  mem_port_arbiter #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (4),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .m0_valid  (m0_valid),
    .m0_ready  (m0_ready),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wstrb  (m0_wstrb),
    .m0_rdata  (m0_rdata),
    .m1_valid  (m1_valid),
    .m1_ready  (m1_ready),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wstrb  (m1_wstrb),
    .m1_rdata  (m1_rdata),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_rdata   (s_rdata),
    .o_grant   (o_grant),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // automatic slave: ready after 0..2 grant cycles
  initial begin
    auto_ready = 1'b0;
    wait_cnt   = 0;
    lat        = 0;
    forever begin
      @(posedge clock);
      #1;
      if (s_valid) begin
        auto_ready = (wait_cnt >= lat);
        wait_cnt++;
      end else begin
        auto_ready = 1'b0;
        wait_cnt   = 0;
        lat        = $urandom_range(0, 2);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst;
    logic        v0;
    logic        v1;
    logic        sr;
    logic [31:0] srd;
    logic        sv;
    logic [1:0]  g;
    logic        r0;
    logic        r1;
    logic        to;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic v0, input logic v1, input logic sr,
                     input logic [31:0] srd, input logic sv, input logic [1:0] g,
                     input logic r0, input logic r1, input logic to,
                     input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1; v.sr = sr; v.srd = srd;
    v.sv = sv; v.g = g; v.r0 = r0; v.r1 = r1; v.to = to; v.rd0 = rd0; v.rd1 = rd1;
    tbl.push_back(v);
  endtask

  localparam logic [AW-1:0] A0  = 16'h0010;
  localparam logic [AW-1:0] A1  = 16'h0100;
  localparam logic [31:0]   WD0 = 32'h1357_2468;
  localparam logic [31:0]   WD1 = 32'hA5A5_A5A5;
  localparam logic [3:0]    WS0 = 4'b0000;
  localparam logic [3:0]    WS1 = 4'b0011;

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      logic [AW-1:0] e_sa;
      logic [31:0]   e_swd;
      logic [3:0]    e_sws;
      @(posedge clock);
      #1;
      reset     = tbl[i].rst;
      m0_valid  = tbl[i].v0;
      m1_valid  = tbl[i].v1;
      man_ready = tbl[i].sr;
      man_rdata = tbl[i].srd;
      e_sa  = (tbl[i].g == 2'b01) ? A0  : (tbl[i].g == 2'b10) ? A1  : '0;
      e_swd = (tbl[i].g == 2'b01) ? WD0 : (tbl[i].g == 2'b10) ? WD1 : 32'h0;
      e_sws = (tbl[i].g == 2'b01) ? WS0 : (tbl[i].g == 2'b10) ? WS1 : 4'h0;
      @(negedge clock);
      chk($sformatf("v%0d s_valid", i),   {31'b0, s_valid},   {31'b0, tbl[i].sv});
      chk($sformatf("v%0d o_busy", i),    {31'b0, o_busy},    {31'b0, tbl[i].sv});
      chk($sformatf("v%0d o_grant", i),   {30'b0, o_grant},   {30'b0, tbl[i].g});
      chk($sformatf("v%0d m0_ready", i),  {31'b0, m0_ready},  {31'b0, tbl[i].r0});
      chk($sformatf("v%0d m1_ready", i),  {31'b0, m1_ready},  {31'b0, tbl[i].r1});
      chk($sformatf("v%0d o_timeout", i), {31'b0, o_timeout}, {31'b0, tbl[i].to});
      chk($sformatf("v%0d m0_rdata", i),  m0_rdata, tbl[i].rd0);
      chk($sformatf("v%0d m1_rdata", i),  m1_rdata, tbl[i].rd1);
      chk($sformatf("v%0d s_addr", i),    {16'b0, s_addr},  {16'b0, e_sa});
      chk($sformatf("v%0d s_wdata", i),   s_wdata, e_swd);
      chk($sformatf("v%0d s_wstrb", i),   {28'b0, s_wstrb}, {28'b0, e_sws});
    end
  endtask

  task automatic run_contention(input int rounds);
    logic [AW-1:0] ad[2];
    logic [31:0]   wd[2];
    logic [3:0]    ws[2];
    logic          done0, done1;
    int            cyc;
    for (int r = 0; r < rounds; r++) begin
      @(posedge clock);
      #1;
      ad[0] = AW'($urandom_range(0, 65535));
      ad[1] = AW'($urandom_range(0, 65535));
      wd[0] = $urandom; wd[1] = $urandom;
      ws[0] = 4'($urandom_range(0, 15));
      ws[1] = 4'($urandom_range(0, 15));
      m0_addr = ad[0]; m0_wdata = wd[0]; m0_wstrb = ws[0];
      m1_addr = ad[1]; m1_wdata = wd[1]; m1_wstrb = ws[1];
      m0_valid = 1'b1;
      m1_valid = 1'b1;
      exp0_q.push_back(mem_fn(ad[0]));
      exp1_q.push_back(mem_fn(ad[1]));
      own_q.push_back(0);
      own_q.push_back(1);
      done0 = 1'b0;
      done1 = 1'b0;
      cyc   = 0;
      while (!(done0 && done1) && cyc < 40) begin
        @(negedge clock);
        if (s_valid && own_q.size() > 0) begin
          chk($sformatf("r%0d grant", r), {30'b0, o_grant}, (own_q[0] == 1) ? 32'd2 : 32'd1);
          chk($sformatf("r%0d s_addr", r), {16'b0, s_addr}, {16'b0, ad[own_q[0]]});
          chk($sformatf("r%0d s_wdata", r), s_wdata, wd[own_q[0]]);
          chk($sformatf("r%0d s_wstrb", r), {28'b0, s_wstrb}, {28'b0, ws[own_q[0]]});
        end
        if (m0_ready && m1_ready) chk($sformatf("r%0d dual ready", r), 32'd1, 32'd0);
        if (m0_ready) begin
          if (exp0_q.size() == 0 || own_q.size() == 0) begin
            chk($sformatf("r%0d m0 unexpected ready", r), 32'd1, 32'd0);
          end else begin
            chk($sformatf("r%0d m0 order", r), 32'd0, own_q.pop_front());
            chk($sformatf("r%0d m0_rdata", r), m0_rdata, exp0_q.pop_front());
          end
          chk($sformatf("r%0d m0 timeout", r), {31'b0, o_timeout}, 32'd0);
          done0 = 1'b1;
        end
        if (m1_ready) begin
          if (exp1_q.size() == 0 || own_q.size() == 0) begin
            chk($sformatf("r%0d m1 unexpected ready", r), 32'd1, 32'd0);
          end else begin
            chk($sformatf("r%0d m1 order", r), 32'd1, own_q.pop_front());
            chk($sformatf("r%0d m1_rdata", r), m1_rdata, exp1_q.pop_front());
          end
          done1 = 1'b1;
        end
        @(posedge clock);
        #1;
        if (done0) m0_valid = 1'b0;
        if (done1) m1_valid = 1'b0;
        cyc++;
      end
      if (!(done0 && done1)) begin
        chk($sformatf("r%0d completion within budget", r), 32'd0, 32'd1);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
      end
    end
    chk("m0 queue drained", exp0_q.size(), 32'd0);
    chk("m1 queue drained", exp1_q.size(), 32'd0);
    chk("grant queue drained", own_q.size(), 32'd0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    m0_valid   = 1'b0;
    m1_valid   = 1'b0;
    m0_addr    = A0;  m0_wdata = WD0; m0_wstrb = WS0;
    m1_addr    = A1;  m1_wdata = WD1; m1_wstrb = WS1;
    man_ready  = 1'b0;
    man_rdata  = 32'h0;
    slave_auto = 1'b0;
    repeat (2) @(posedge clock);

    //   rst v0 v1 sr srd              sv g      r0 r1 to rd0              rd1
    // reset state
    add(0, 0, 0, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    add(0, 0, 0, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    // m0 read, slave ready on 3rd grant cycle
    add(1, 1, 0, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 0, 0, 32'h0,           1, 2'b01, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 0, 0, 32'h0,           1, 2'b01, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 0, 1, 32'h1234_5678,   1, 2'b01, 1, 0, 0, 32'h1234_5678,   32'h0);
    add(1, 0, 0, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    // watchdog fires on 4th grant cycle
    add(1, 1, 0, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 0, 0, 32'h0,           1, 2'b01, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 0, 0, 32'h0,           1, 2'b01, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 0, 0, 32'h0,           1, 2'b01, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 0, 0, 32'h0,           1, 2'b01, 1, 0, 1, 32'hDEAD_BEEF,   32'h0);
    add(1, 0, 0, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    // slave ready on the expiry cycle wins
    add(1, 1, 0, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 0, 0, 32'h0,           1, 2'b01, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 0, 0, 32'h0,           1, 2'b01, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 0, 0, 32'h0,           1, 2'b01, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 0, 1, 32'hCAFE_F00D,   1, 2'b01, 1, 0, 0, 32'hCAFE_F00D,   32'h0);
    add(1, 0, 0, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    // reset in GRANT1 with last_grant=0; afterwards m0 still wins first
    add(1, 0, 1, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    add(1, 0, 1, 0, 32'h0,           1, 2'b10, 0, 0, 0, 32'h0,           32'h0);
    add(0, 0, 1, 1, 32'h5555_5555,   0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 1, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 1, 0, 32'h0,           1, 2'b01, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 1, 1, 32'h0BAD_F00D,   1, 2'b01, 1, 0, 0, 32'h0BAD_F00D,   32'h0);
    // m1 write passthrough
    add(1, 0, 1, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    add(1, 0, 1, 0, 32'h0,           1, 2'b10, 0, 0, 0, 32'h0,           32'h0);
    add(1, 0, 1, 1, 32'h1111_2222,   1, 2'b10, 0, 1, 0, 32'h0,           32'h1111_2222);
    add(1, 0, 0, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    // m0 drops valid mid-grant; m1 then served
    add(1, 1, 1, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    add(1, 1, 1, 0, 32'h0,           1, 2'b01, 0, 0, 0, 32'h0,           32'h0);
    add(1, 0, 1, 0, 32'h0,           1, 2'b01, 0, 0, 0, 32'h0,           32'h0);
    add(1, 0, 1, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);
    add(1, 0, 1, 0, 32'h0,           1, 2'b10, 0, 0, 0, 32'h0,           32'h0);
    add(1, 0, 1, 1, 32'h7777_7777,   1, 2'b10, 0, 1, 0, 32'h0,           32'h7777_7777);
    add(1, 0, 0, 0, 32'h0,           0, 2'b00, 0, 0, 0, 32'h0,           32'h0);

    run_table();

    // contention: both request every round, automatic slave
    @(posedge clock);
    #1;
    man_ready  = 1'b0;
    slave_auto = 1'b1;
    run_contention(8);

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
